// File: rtl/alu_seq_pkg.sv
// alu_seq_pkg: request op codes, ALU op encodings and sequencer FSM states
package alu_seq_pkg;
  localparam logic [2:0] OP_ADD = 3'd0, OP_SUB = 3'd1, OP_AND = 3'd2, OP_OR = 3'd3,
                         OP_XOR = 3'd4, OP_SHL = 3'd5, OP_SHR = 3'd6, OP_PASS = 3'd7;
  localparam logic [3:0] ALU_ADD = 4'b0011, ALU_SUB = 4'b0111, ALU_AND = 4'b1101,
                         ALU_OR = 4'b1100, ALU_XOR = 4'b1110, ALU_SHL = 4'b1011,
                         ALU_SHF = 4'b1111;
  typedef enum logic [1:0] {S_IDLE = 2'd0, S_RUN = 2'd1, S_FLUSH = 2'd2} state_t;
endpackage

// File: rtl/alu_seq_opdec.sv
// alu_seq_opdec: request op -> ALU controls and flag validity; op 7 is CMP when ALU_SEQ_CMP_EN is defined, else PASS
module alu_seq_opdec
  import alu_seq_pkg::*;
(
  input  logic [2:0] i_op,
  input  logic       i_ci,
  output logic [3:0] o_alu_op,
  output logic       o_right,
  output logic       o_ci,
  output logic       o_msb_first,
  output logic       o_co_valid,
  output logic       o_v_valid,
  output logic       o_hold
);
  // decode the request op into ALU op, first-byte carry, walk order and flag qualifiers
  always_comb begin
    o_alu_op    = ALU_SHF;
    o_right     = 1'b0;
    o_ci        = i_ci;
    o_msb_first = 1'b0;
    o_co_valid  = 1'b0;
    o_v_valid   = 1'b0;
    o_hold      = 1'b0;
    case (i_op)
      OP_ADD: begin o_alu_op = ALU_ADD; o_co_valid = 1'b1; o_v_valid = 1'b1; end
      OP_SUB: begin o_alu_op = ALU_SUB; o_co_valid = 1'b1; o_v_valid = 1'b1; end
      OP_AND: begin o_alu_op = ALU_AND; o_ci = 1'b0; end
      OP_OR:  begin o_alu_op = ALU_OR;  o_ci = 1'b0; end
      OP_XOR: begin o_alu_op = ALU_XOR; o_ci = 1'b0; end
      OP_SHL: begin o_alu_op = ALU_SHL; o_co_valid = 1'b1; end
      OP_SHR: begin o_right = 1'b1; o_msb_first = 1'b1; o_co_valid = 1'b1; end
      default: begin
`ifdef ALU_SEQ_CMP_EN
        o_alu_op   = ALU_SUB;
        o_ci       = 1'b1;
        o_co_valid = 1'b1;
        o_v_valid  = 1'b1;
        o_hold     = 1'b1;
`else
        o_ci       = 1'b0;
`endif
      end
    endcase
  end
endmodule

// File: rtl/alu_mb_seq.sv
// alu_mb_seq: issues a 1..MAX_BYTES byte request to a shared registered 8-bit ALU, chaining carry; ALU_SEQ_CMP_EN selects CMP for op 7
module alu_mb_seq
  import alu_seq_pkg::*;
#(
  parameter int MAX_BYTES = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   rdy,
  input  logic                   req,
  input  logic [2:0]             req_op,
  input  logic [1:0]             req_len,
  input  logic [8*MAX_BYTES-1:0] req_a,
  input  logic [8*MAX_BYTES-1:0] req_b,
  input  logic                   req_ci,
  output logic                   busy,
  output logic                   done,
  output logic [8*MAX_BYTES-1:0] res,
  output logic                   res_co,
  output logic                   res_v,
  output logic                   res_n,
  output logic                   res_z,
  output logic [3:0]             alu_op,
  output logic                   alu_right,
  output logic                   alu_ci,
  output logic                   alu_bcd,
  output logic                   alu_rdy,
  output logic [7:0]             alu_ai,
  output logic [7:0]             alu_bi,
  input  logic [7:0]             alu_out,
  input  logic                   alu_co,
  input  logic                   alu_v
);
  localparam int         W    = 8 * MAX_BYTES;
  localparam logic [1:0] LMAX = 2'(MAX_BYTES - 1);
  state_t         r_state, w_state_nx;
  logic [W-1:0]   r_a, r_b, r_acc, r_res, w_acc_cap;
  logic [1:0]     r_len, r_idx, r_prev, w_len, w_idx_nx;
  logic [3:0]     r_alu_op, w_dec_op;
  logic           r_right, r_ci, r_msb, r_cov, r_vv, r_hold, r_first, r_done;
  logic           r_co, r_v, r_n, r_z, w_last, w_accept;
  logic           w_dec_right, w_dec_ci, w_dec_msb, w_dec_cov, w_dec_vv, w_dec_hold;
  alu_seq_opdec u_dec (
    .i_op        (req_op),
    .i_ci        (req_ci),
    .o_alu_op    (w_dec_op),
    .o_right     (w_dec_right),
    .o_ci        (w_dec_ci),
    .o_msb_first (w_dec_msb),
    .o_co_valid  (w_dec_cov),
    .o_v_valid   (w_dec_vv),
    .o_hold      (w_dec_hold)
  );
  // next state, byte walk, result-slot capture and ALU-facing controls
  always_comb begin
    w_len      = (req_len > LMAX) ? LMAX : req_len;
    w_accept   = (r_state == S_IDLE) && req && rdy;
    w_last     = r_msb ? (r_idx == 2'd0) : (r_idx == r_len);
    w_idx_nx   = r_msb ? r_idx - 2'd1 : r_idx + 2'd1;
    w_acc_cap  = r_acc;
    w_acc_cap[{r_prev, 3'b000} +: 8] = alu_out;
    w_state_nx = !rdy ? r_state :
                 (r_state == S_IDLE)  ? (req ? S_RUN : S_IDLE) :
                 (r_state == S_RUN)   ? (w_last ? S_FLUSH : S_RUN) : S_IDLE;
    busy       = r_state != S_IDLE;
    alu_rdy    = rdy && (r_state == S_RUN || r_state == S_FLUSH);
    alu_ci     = r_first ? r_ci : alu_co;
    alu_ai     = r_a[{r_idx, 3'b000} +: 8];
    alu_bi     = r_b[{r_idx, 3'b000} +: 8];
  end
  // FSM state register
  always_ff @(posedge clk) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_state_nx;
  end
  // request latch, per-byte result capture and final flag registration; rdy=0 freezes all of it
  always_ff @(posedge clk) begin
    if (reset) begin
      r_a      <= '0;
      r_b      <= '0;
      r_acc    <= '0;
      r_res    <= '0;
      r_len    <= '0;
      r_idx    <= '0;
      r_prev   <= '0;
      r_alu_op <= ALU_SHF;
      r_right  <= 1'b0;
      r_ci     <= 1'b0;
      r_msb    <= 1'b0;
      r_cov    <= 1'b0;
      r_vv     <= 1'b0;
      r_hold   <= 1'b0;
      r_first  <= 1'b0;
      r_done   <= 1'b0;
      r_co     <= 1'b0;
      r_v      <= 1'b0;
      r_n      <= 1'b0;
      r_z      <= 1'b0;
    end else if (rdy) begin
      r_done <= 1'b0;
      if (w_accept) begin
        r_a      <= req_a;
        r_b      <= req_b;
        r_acc    <= '0;
        r_len    <= w_len;
        r_idx    <= w_dec_msb ? w_len : 2'd0;
        r_alu_op <= w_dec_op;
        r_right  <= w_dec_right;
        r_ci     <= w_dec_ci;
        r_msb    <= w_dec_msb;
        r_cov    <= w_dec_cov;
        r_vv     <= w_dec_vv;
        r_hold   <= w_dec_hold;
        r_first  <= 1'b1;
      end
      if (r_state == S_RUN) begin
        if (!r_first) r_acc <= w_acc_cap;
        r_prev  <= r_idx;
        r_idx   <= w_idx_nx;
        r_first <= 1'b0;
      end
      if (r_state == S_FLUSH) begin
        r_acc  <= w_acc_cap;
        if (!r_hold) r_res <= w_acc_cap;
        r_co   <= r_cov & alu_co;
        r_v    <= r_vv & alu_v;
        r_n    <= w_acc_cap[{r_len, 3'b111}];
        r_z    <= ~|w_acc_cap;
        r_done <= 1'b1;
      end
    end
  end
  assign done      = r_done;
  assign res       = r_res;
  assign res_co    = r_co;
  assign res_v     = r_v;
  assign res_n     = r_n;
  assign res_z     = r_z;
  assign alu_op    = r_alu_op;
  assign alu_right = r_right;
  assign alu_bcd   = 1'b0;
endmodule
